// File: rtl/switch_cfg_regs.sv
// Memory-mapped config block: shadow port addresses, CTRL with COMMIT, saturating ERR_CNT.
// Ack two edges after request capture; master must drop mem_sel_en before the next request.
module switch_cfg_regs #(
    parameter int NUM_PORTS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mem_sel_en,
    input  logic [7:0]             mem_addr,
    input  logic [7:0]             mem_wr_data,
    input  logic                   mem_wr_rd_s,
    output logic [7:0]             mem_rd_data,
    output logic                   mem_ack,
    output logic [NUM_PORTS*8-1:0] port_addr,
    output logic                   sw_en
);

    typedef enum logic [1:0] {IDLE, ACCESS, ACK, WAIT_REL} state_t;

    localparam logic [7:0] ADDR_CTRL = 8'h10;
    localparam logic [7:0] ADDR_ERR  = 8'h11;

    state_t                    state_q, state_d;
    logic [7:0]                addr_q, addr_d;
    logic [7:0]                wdat_q, wdat_d;
    logic                      wr_q, wr_d;
    logic [7:0]                rd_q, rd_d;
    logic [7:0]                err_q, err_d;
    logic                      sw_en_q, sw_en_d;
    logic [NUM_PORTS-1:0][7:0] shadow_q, shadow_d;
    logic [NUM_PORTS-1:0][7:0] port_q, port_d;
    logic                      hit_shadow;
    logic [7:0]                shadow_rd;

    always_comb begin
        hit_shadow = 1'b0;
        shadow_rd  = 8'h00;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (addr_q == 8'(i)) begin
                hit_shadow = 1'b1;
                shadow_rd  = shadow_q[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdat_d   = wdat_q;
        wr_d     = wr_q;
        rd_d     = rd_q;
        err_d    = err_q;
        sw_en_d  = sw_en_q;
        shadow_d = shadow_q;
        port_d   = port_q;
        case (state_q)
            IDLE: begin
                if (mem_sel_en) begin
                    state_d = ACCESS;
                    addr_d  = mem_addr;
                    wdat_d  = mem_wr_data;
                    wr_d    = mem_wr_rd_s;
                end
            end
            ACCESS: begin
                // All register side effects land on the edge leaving ACCESS.
                state_d = ACK;
                rd_d    = 8'h00;
                if (hit_shadow) begin
                    if (wr_q) begin
                        for (int i = 0; i < NUM_PORTS; i++) begin
                            if (addr_q == 8'(i)) shadow_d[i] = wdat_q;
                        end
                    end else begin
                        rd_d = shadow_rd;
                    end
                end else if (addr_q == ADDR_CTRL) begin
                    if (wr_q) begin
                        sw_en_d = wdat_q[0];
                        if (wdat_q[1]) port_d = shadow_q;
                    end else begin
                        rd_d = {7'b0, sw_en_q};
                    end
                end else if (addr_q == ADDR_ERR) begin
                    if (wr_q) err_d = 8'h00;
                    else      rd_d  = err_q;
                end else begin
                    if (!wr_q) rd_d = 8'hFF;
                    if (err_q != 8'hFF) err_d = err_q + 8'h01;
                end
            end
            ACK: begin
                state_d = WAIT_REL;
            end
            WAIT_REL: begin
                if (!mem_sel_en) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= 8'h00;
            wdat_q   <= 8'h00;
            wr_q     <= 1'b0;
            rd_q     <= 8'h00;
            err_q    <= 8'h00;
            sw_en_q  <= 1'b0;
            shadow_q <= '0;
            port_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdat_q   <= wdat_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            err_q    <= err_d;
            sw_en_q  <= sw_en_d;
            shadow_q <= shadow_d;
            port_q   <= port_d;
        end
    end

    assign mem_ack     = (state_q == ACK);
    assign mem_rd_data = (state_q == ACK) ? rd_q : 8'h00;
    assign port_addr   = port_q;
    assign sw_en       = sw_en_q;

endmodule
